serial_adder_pipe: RTL and testbench
====================================

// Module: serial_adder_pipe
// PURPOSE
//  Multi-cycle, digit-serial adder: adds two WIDTH-bit operands plus carry-in
//  DIGIT bits per clock, using a DIGIT-long ripple chain of full-adder cells
//  and a registered inter-digit carry. This is the parametrised successor of
//  the single-bit structural full adder. It trades latency for area, and sits
//  behind valid/ready handshakes in datapaths where a full-width adder is too large.
// PARAMETERS
//  WIDTH  16  operand/sum width in bits; must be >= 1
//  DIGIT  4   bits added per cycle; 1 <= DIGIT <= WIDTH, WIDTH % DIGIT == 0
//  (derived) CYCLES = WIDTH/DIGIT; cnt width = max(1,$clog2(CYCLES))
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operands a/b/cin valid
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in
//  out_valid  out  1      sum/cout valid (high only in DONE)
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  registered result (a+b+cin) mod 2^WIDTH
//  cout       out  1      registered carry-out of bit WIDTH-1
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, sum=0, cout=0, carry reg=0, cnt=0, busy=0.
//    Once reset has been applied, in_ready=1.
//  FSM IDLE->RUN->DONE->IDLE. in_ready=(state==IDLE); out_valid=(state==DONE).
//  IDLE: on in_valid&in_ready, capture a, b into shift regs and cin into the
//    carry reg, clear cnt, and go to RUN. in_valid while not ready is ignored.
//  RUN: each cycle, add DIGIT LSBs of the a/b shift regs with the carry reg.
//    Shift the DIGIT result bits into sum from the MSB end, right-shift a/b by
//    DIGIT, update the carry reg, and increment cnt. At cnt==CYCLES-1, that
//    edge loads the final slice, sets cout, and goes to DONE.
//  Latency: out_valid rises exactly CYCLES clocks after the accept edge.
//    No overlap: one operation in flight.
//  DONE: sum/cout are held stable while out_ready=0 (unbounded backpressure).
//    On out_ready=1, go to IDLE; in_ready=1 on the next cycle. A new accept
//    cannot occur in the same cycle as the output handshake.
//  Overflow wraps modulo 2^WIDTH; the carry is reported only on cout.
//  DIGIT==WIDTH: single RUN cycle (latency 1). DIGIT==1: bit-serial.
//  rst in any state (including mid-RUN) returns to reset values at that edge.
//    The partial result is discarded; out_valid never asserts for an aborted op.
//  sum/cout contents are don't-care outside DONE, except reset value 0.
// CONFIGURATION
//  SERIAL_ADDER_SUB_EN defined:
//    - Adds port sub (in, 1), sampled with operands at accept.
//    - sub=1: compute a + ~b + 1 (cin ignored). cout=1 means no borrow
//      (a>=b unsigned).
//    - sub=0: identical to add mode.
//  SERIAL_ADDER_SUB_EN undefined: no sub port; always a+b+cin.
// TESTING
//  1. rst=1 for 2 clks -> out_valid=0, sum=0, cout=0, busy=0; in_ready=1 after.
//  2. W16/D4: a=0x1234, b=0x4321, cin=0 -> out_valid 4 clks after accept,
//     sum=0x5555, cout=0.
//  3. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1.
//     a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
//  4. out_ready=0 for 5 clks in DONE, in_valid pulsed -> sum/cout held,
//     in_ready=0, no capture. Release -> IDLE next clk.
//  5. rst=1 on 2nd RUN cycle -> IDLE next edge, no out_valid. The next op
//     0x00FF+0x0001 gives 0x0100.
//  6. SUB_EN, sub=1: a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0.
//     a=7, b=5 -> sum=0x0002, cout=1.
//  Also: random a/b/cin versus the golden {cout,sum}=a+b+cin for DIGIT=1,4,16.

Source files
------------

// File: rtl/serial_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pipe
// Description : Digit-serial adder. Each clock it adds DIGIT bits of a and b
//               through a ripple chain and keeps the inter-digit carry in a
//               register. Optional macro SERIAL_ADDER_SUB_EN adds a sub port.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int c_cycles = WIDTH / DIGIT;
    localparam int c_cnt_w  = (c_cycles > 1) ? $clog2(c_cycles) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_cycles - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_b_in;
    logic               w_cin_in;
    logic [DIGIT:0]     w_c;
    logic [DIGIT-1:0]   w_s;
    logic [WIDTH-1:0]   w_a_shift;
    logic [WIDTH-1:0]   w_b_shift;
    logic [WIDTH-1:0]   w_sum_shift;

    assign w_accept = in_valid && (r_state == c_st_idle);
    assign w_last   = (r_cnt == c_cnt_last);

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction as a + ~b + 1; the forced carry replaces cin.
    assign w_b_in   = sub ? ~b : b;
    assign w_cin_in = sub ? 1'b1 : cin;
`else
    assign w_b_in   = b;
    assign w_cin_in = cin;
`endif

    assign w_c[0] = r_carry;

    genvar gi;
    generate
        for (gi = 0; gi < DIGIT; gi++) begin : g_fa
            assign w_s[gi]   = r_a[gi] ^ r_b[gi] ^ w_c[gi];
            assign w_c[gi+1] = (r_a[gi] & r_b[gi]) | (w_c[gi] & (r_a[gi] ^ r_b[gi]));
        end

        if (DIGIT == WIDTH) begin : g_single_digit
            assign w_a_shift   = '0;
            assign w_b_shift   = '0;
            assign w_sum_shift = w_s;
        end else begin : g_multi_digit
            // Result digits enter at the MSB end so the first digit lands at bit 0.
            assign w_a_shift   = {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
            assign w_b_shift   = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
            assign w_sum_shift = {w_s, r_sum[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_accept)  w_state_nxt = c_st_run;
            c_st_run:  if (w_last)    w_state_nxt = c_st_done;
            c_st_done: if (out_ready) w_state_nxt = c_st_idle;
            default:                  w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= w_b_in;
            r_carry <= w_cin_in;
            r_cnt   <= '0;
        end else if (r_state == c_st_run) begin
            r_a     <= w_a_shift;
            r_b     <= w_b_shift;
            r_sum   <= w_sum_shift;
            r_carry <= w_c[DIGIT];
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_cout <= w_c[DIGIT];
            end
        end
    end

    assign in_ready  = (r_state == c_st_idle);
    assign out_valid = (r_state == c_st_done);
    assign busy      = (r_state != c_st_idle);
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder_pipe
// Description : Drives three adders (DIGIT = 1, 4, 16) with shared stimulus and
//               checks them against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        cin = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
`ifdef SERIAL_ADDER_SUB_EN
    logic        sub = 1'b0;
`endif

    logic        ir [3];
    logic        ov [3];
    logic        co [3];
    logic        bz [3];
    logic [15:0] sm [3];

    int checks = 0;
    int errors = 0;
    int cyc [3] = '{16, 4, 1};

    bit          m_init = 1'b0;
    bit          m_pend [3];
    bit          m_val  [3];
    int          m_left [3];
    logic [16:0] m_res  [3];

    always #5 clk = ~clk;

    serial_adder_pipe #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
        .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(ov[0]), .out_ready(out_ready), .sum(sm[0]), .cout(co[0]), .busy(bz[0])
    );

    serial_adder_pipe #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
        .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(ov[1]), .out_ready(out_ready), .sum(sm[1]), .cout(co[1]), .busy(bz[1])
    );

    serial_adder_pipe #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
        .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(ov[2]), .out_ready(out_ready), .sum(sm[2]), .cout(co[2]), .busy(bz[2])
    );

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h expected=%0h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    // Reference model: result is plain arithmetic, timing is accept + CYCLES edges.
    initial begin
        logic        rs, iv, orr, tc, ts;
        logic [15:0] ta, tbv;
        forever begin
            @(posedge clk);
            rs = rst; iv = in_valid; orr = out_ready; ta = a; tbv = b; tc = cin; ts = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            ts = sub;
`endif
            #1;
            for (int k = 0; k < 3; k++) begin
                if (rs) begin
                    m_init    = 1'b1;
                    m_pend[k] = 1'b0;
                    m_val[k]  = 1'b0;
                end else if (m_val[k]) begin
                    if (orr) m_val[k] = 1'b0;
                end else if (m_pend[k]) begin
                    m_left[k]--;
                    if (m_left[k] == 0) begin
                        m_pend[k] = 1'b0;
                        m_val[k]  = 1'b1;
                    end
                end else if (iv) begin
                    m_pend[k] = 1'b1;
                    m_left[k] = cyc[k];
                    if (ts) m_res[k] = {1'b0, ta} + {1'b0, ~tbv} + 17'd1;
                    else    m_res[k] = {1'b0, ta} + {1'b0, tbv} + {16'd0, tc};
                end
                if (m_init) begin
                    chk("in_ready", k, {31'd0, ir[k]}, {31'd0, !(m_pend[k] || m_val[k])});
                    chk("busy", k, {31'd0, bz[k]}, {31'd0, (m_pend[k] || m_val[k])});
                    chk("out_valid", k, {31'd0, ov[k]}, {31'd0, m_val[k]});
                    if (m_val[k]) begin
                        chk("sum", k, {16'd0, sm[k]}, {16'd0, m_res[k][15:0]});
                        chk("cout", k, {31'd0, co[k]}, {31'd0, m_res[k][16]});
                    end
                    if (rs) begin
                        chk("reset_sum", k, {16'd0, sm[k]}, 32'd0);
                        chk("reset_cout", k, {31'd0, co[k]}, 32'd0);
                    end
                end
            end
        end
    end

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv, input logic tc,
                          input logic ts, input logic [15:0] es, input logic ec,
                          input bit lit, input int hold);
        int n;
        int lat;
        @(negedge clk);
        n = 0;
        while (!(ir[0] && ir[1] && ir[2]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 1, 32'd1, 32'd0);
        a = ta; b = tbv; cin = tc; in_valid = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub = ts;
`else
        if (ts) chk("sub_unsupported", 1, 32'd1, 32'd0);
`endif
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!ov[1] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (lit) chk("latency_d4", 1, lat, 32'd4);
        n = 0;
        while (!(ov[0] && ov[1] && ov[2]) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("done_timeout", 0, 32'd1, 32'd0);
        if (lit) begin
            chk("lit_sum", 1, {16'd0, sm[1]}, {16'd0, es});
            chk("lit_cout", 1, {31'd0, co[1]}, {31'd0, ec});
            chk("model_pin", 1, {15'd0, m_res[1]}, {15'd0, ec, es});
        end
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                a = 16'hAAAA; b = 16'h5555; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (lit && hold > 0) begin
            chk("held_sum", 1, {16'd0, sm[1]}, {16'd0, es});
            chk("held_cout", 1, {31'd0, co[1]}, {31'd0, ec});
            chk("held_in_ready", 1, {31'd0, ir[1]}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_after_release", 1, {31'd0, ir[1]}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] ra, rb;
        logic        rc, rsub;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("in_ready_after_reset", 1, {31'd0, ir[1]}, 32'd1);

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b1, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b1, 5);

        // Abort an operation on its second RUN cycle.
        @(negedge clk);
        a = 16'h1111; b = 16'h0002; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out_valid", 1, {31'd0, ov[1]}, 32'd0);
        chk("abort_in_ready", 1, {31'd0, ir[1]}, 32'd1);
        repeat (6) @(negedge clk);
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1, 0);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b1, 0);
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b1, 0);
        run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b1, 2);
`endif

        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rsub = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            rsub = 1'($urandom);
`endif
            run_op(ra, rb, rc, rsub, 16'h0000, 1'b0, 1'b0, i % 3);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
